// File: rtl/bus_req_queue.sv
// bus_req_queue: request buffer in front of one bus master port.
// Clients push read/write requests into a FIFO at full rate. The requests are issued to the
// master port one at a time, in push order. Each completion is returned as a one-cycle
// response strobe.
//
// Ports
//   clk, rstn                        clock (rising edge), asynchronous active-low reset
//   c_valid/c_ready/c_addr/c_wdata/c_mode
//                                    client push interface (c_ready = not full, registered)
//   r_valid/r_mode/r_rdata/r_err     completion strobe with mode, read data and error flag
//   m_valid/m_ready/m_addr/m_wdata/m_mode/m_rdata
//                                    master port handshake (m_ready = 1 means the master is idle)
//   count                            entries held, including the one in flight
//
// Optional feature: define REQ_TIMEOUT_EN to abandon a request that the master never accepts
// (m_ready still high after TIMEOUT_CYCLES cycles in WAIT_BUSY). The abandoned request
// completes with r_err=1. Without the macro, WAIT_BUSY waits forever and r_err is tied to 0.
module bus_req_queue #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned DEPTH_LOG2     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  c_valid,
    output logic                  c_ready,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    input  logic                  c_mode,
    output logic                  r_valid,
    output logic                  r_mode,
    output logic [DATA_WIDTH-1:0] r_rdata,
    output logic                  r_err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  m_mode,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned ENT_W = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

    typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StWaitDone, StSettle} state_e;

    // Entry layout: {addr, wdata, mode}
    logic [ENT_W-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  c_ready_q, c_ready_d;
    state_e                state_q, state_d;
    logic                  m_valid_q, m_valid_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic                  m_mode_q, m_mode_d;
    logic                  r_valid_q, r_valid_d;
    logic                  r_mode_q, r_mode_d;
    logic [DATA_WIDTH-1:0] r_rdata_q, r_rdata_d;
    logic                  push, pop;
    logic [ENT_W-1:0]      head;

`ifdef REQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = 1;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            r_err_q, r_err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign push = c_valid && c_ready_q;
    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {c_addr, c_wdata, c_mode};
        end
    end

    // Pointers and occupancy; the head stays counted until its completion pops it.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - COUNT_ONE;
        end
        c_ready_d = (count_d != COUNT_FULL);
    end

    always_comb begin
        state_d   = state_q;
        m_valid_d = 1'b0;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_mode_d  = m_mode_q;
        r_valid_d = 1'b0;
        r_mode_d  = r_mode_q;
        r_rdata_d = r_rdata_q;
        pop       = 1'b0;
`ifdef REQ_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        r_err_d   = r_err_q;
`endif
        case (state_q)
            StIdle: begin
                if ((count_q != '0) && m_ready) begin
                    state_d   = StIssue;
                    m_valid_d = 1'b1;
                    m_addr_d  = head[ENT_W-1 -: ADDR_WIDTH];
                    m_wdata_d = head[DATA_WIDTH:1];
                    m_mode_d  = head[0];
                end
            end
            StIssue: begin
                state_d = StWaitBusy;
`ifdef REQ_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            StWaitBusy: begin
                if (!m_ready) begin
                    state_d = StWaitDone;
`ifdef REQ_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    // Master never accepted: complete the head with an error.
                    state_d   = StIdle;
                    pop       = 1'b1;
                    r_valid_d = 1'b1;
                    r_mode_d  = head[0];
                    r_rdata_d = '0;
                    r_err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
`endif
                end
            end
            StWaitDone: begin
                if (m_ready) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                state_d   = StIdle;
                pop       = 1'b1;
                r_valid_d = 1'b1;
                r_mode_d  = head[0];
                r_rdata_d = head[0] ? '0 : m_rdata;
`ifdef REQ_TIMEOUT_EN
                r_err_d   = 1'b0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            c_ready_q <= 1'b1;
            state_q   <= StIdle;
            m_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_mode_q  <= 1'b0;
            r_valid_q <= 1'b0;
            r_mode_q  <= 1'b0;
            r_rdata_q <= '0;
`ifdef REQ_TIMEOUT_EN
            to_cnt_q  <= '0;
            r_err_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            c_ready_q <= c_ready_d;
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_mode_q  <= m_mode_d;
            r_valid_q <= r_valid_d;
            r_mode_q  <= r_mode_d;
            r_rdata_q <= r_rdata_d;
`ifdef REQ_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            r_err_q   <= r_err_d;
`endif
        end
    end

    assign c_ready = c_ready_q;
    assign count   = count_q;
    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_mode  = m_mode_q;
    assign r_valid = r_valid_q;
    assign r_mode  = r_mode_q;
    assign r_rdata = r_rdata_q;
`ifdef REQ_TIMEOUT_EN
    assign r_err   = r_err_q;
`else
    assign r_err   = 1'b0;
`endif

endmodule
